spi_master_mc: RTL and testbench

//  Parametrised multi-slave SPI master; successor to the fixed-mode 16-bit master on the SPI loopback board.

---
 rtl/spi_master_mc_pkg.sv | 26 ++
 rtl/spi_master_mc_if.sv | 40 ++++
 rtl/spi_master_mc_half_tick.sv | 37 +++
 rtl/spi_master_mc.sv | 171 +++++++++++++++++
 tb/tb_spi_master_mc.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_mc_pkg.sv
// Shared types and constants for the multi-slave SPI master: FSM state
// encoding, SPI mode codes and the chip-select index width helper.
package spi_master_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_XFER  = 2'd2,
    ST_TRAIL = 2'd3
  } spi_state_e;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int DEFAULT_DATA_W = 16;

  // One code beyond the last slave index is kept representable so an
  // out-of-range selection can be requested and rejected with err.
  function automatic int cs_width(input int ncs);
    return (ncs < 1) ? 1 : $clog2(ncs + 1);
  endfunction

endpackage

// File: rtl/spi_master_mc_if.sv
// Control/data bundle between the transfer requester and the SPI master,
// plus the board-facing SPI pins.
interface spi_master_mc_if #(
  parameter int DATA_W = 16,
  parameter int NCS    = 2,
  parameter int DIV_W  = 8
);
  localparam int CS_W = spi_master_mc_pkg::cs_width(NCS);

  // Handshake: st is a 1-clk request taken only while busy=0 (ignored, not
  // queued, while busy=1). done is a 1-clk pulse with DO valid and busy
  // already low, so a new st may be presented in the same clk as done.
  logic              st;
  logic              abort;
  logic [DATA_W-1:0] DI;
  logic [DIV_W-1:0]  div;
  logic              cpol;
  logic              cpha;
  logic [CS_W-1:0]   cs_sel;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic [NCS-1:0]    CS_n;
  logic [DATA_W-1:0] DO;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        cb_bit;

  modport master (
    input  st, abort, DI, div, cpol, cpha, cs_sel, MISO,
    output SCLK, MOSI, CS_n, DO, busy, done, err, cb_bit
  );

  modport slave (
    output st, abort, DI, div, cpol, cpha, cs_sel, MISO,
    input  SCLK, MOSI, CS_n, DO, busy, done, err, cb_bit
  );

endinterface

// File: rtl/spi_master_mc_half_tick.sv
// Half-period tick generator: counts 0..div and pulses tick on the last
// count, so every enabled span of div+1 clk yields exactly one tick.
module spi_master_mc_half_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap   = (cnt_q == div_i);
  assign tick_o = en_i && !clear_i && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master with runtime CPOL/CPHA and divider, selectable
// bit order, abort, and one-hot-low chip selects.
module spi_master_mc
  import spi_master_mc_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NCS       = 2,
  parameter int DIV_W     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   clr,
  spi_master_mc_if.master        bus,
  output spi_state_e             dbg_state_o
);

  localparam int              CS_W  = cs_width(NCS);
  localparam logic [7:0]      DW8   = 8'(DATA_W);
  localparam logic [7:0]      EDGES = 8'(2 * DATA_W);
  localparam logic [CS_W-1:0] NCS_C = CS_W'(NCS);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] do_q, do_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic [NCS-1:0]    cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        cb_q, cb_d;
  logic [7:0]        edge_q, edge_d;
  logic              tick;
  logic              leading;
  logic              sample_edge;

  spi_master_mc_half_tick #(.DIV_W(DIV_W)) u_half_tick (
    .clk_i   (clk),
    .rst_ni  (clr),
    .clear_i (state_q == ST_IDLE),
    .en_i    (state_q != ST_IDLE),
    .div_i   (div_q),
    .tick_o  (tick)
  );

  // edge_q counts SCLK edges already issued; even count means the next one leads.
  assign leading     = ~edge_q[0];
  assign sample_edge = leading ^ cpha_q;

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    do_d    = do_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cb_d    = cb_q;
    edge_d  = edge_q;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = bus.cpol;
        if (bus.st) begin
          if (bus.cs_sel >= NCS_C) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_LEAD;
            tx_d    = bus.DI;
            rx_d    = '0;
            div_d   = bus.div;
            cpol_d  = bus.cpol;
            cpha_d  = bus.cpha;
            cb_d    = '0;
            edge_d  = '0;
            for (int i = 0; i < NCS; i++) begin
              cs_n_d[i] = (CS_W'(i) != bus.cs_sel);
            end
          end
        end
      end
      ST_LEAD: begin
        if (tick) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + 8'd1;
          if (sample_edge) begin
            if (LSB_FIRST) rx_d = {bus.MISO, rx_q[DATA_W-1:1]};
            else           rx_d = {rx_q[DATA_W-2:0], bus.MISO};
            cb_d = cb_q + 8'd1;
          end else if ((cb_q != 8'd0) && (cb_q < DW8)) begin
            // Gating on cb_q skips the first leading edge in cpha=1 (bit 0
            // is already on MOSI) and holds the last bit after the final edge.
            if (LSB_FIRST) tx_d = tx_q >> 1;
            else           tx_d = tx_q << 1;
          end
          if (edge_q == EDGES - 8'd1) state_d = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = '1;
          do_d    = rx_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      cs_n_d  = '1;
      sclk_d  = cpol_q;
      cb_d    = '0;
      done_d  = 1'b0;
      do_d    = do_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      do_q    <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cb_q    <= '0;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      do_q    <= do_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cb_q    <= cb_d;
      edge_q  <= edge_d;
    end
  end

  assign bus.SCLK   = sclk_q;
  assign bus.MOSI   = (state_q != ST_IDLE) && (LSB_FIRST ? tx_q[0] : tx_q[DATA_W-1]);
  assign bus.CS_n   = cs_n_q;
  assign bus.DO     = do_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.cb_bit = cb_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: timeline model of the SPI waveform, a behavioural
// slave returning a fixed word, and directed scenarios with literal checks.
module tb_spi_master_mc;
  import spi_master_mc_pkg::*;

  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  spi_state_e dbg_state;

  spi_master_mc_if #(.DATA_W(DW), .NCS(2), .DIV_W(8)) bus ();

  spi_master_mc #(.DATA_W(DW), .NCS(2), .DIV_W(8), .LSB_FIRST(1'b0)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the active transfer, armed by the driver when a start is expected to be taken.
  bit          m_active = 1'b0;
  int          m_t0 = 0;
  int          m_div = 0;
  logic [15:0] m_di = '0;
  logic        m_cpol = 1'b0;
  logic        m_cpha = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [15:0] slave_word = 16'h3C5A;

  always @(negedge clk) begin
    if (m_active && clr) begin
      int t, h, last, p, e, samp, shifts;
      logic [1:0] exp_cs;
      t = cyc - m_t0;
      h = m_div + 1;
      last = (2 * DW + 2) * h;
      if (t >= last) begin
        chk("end_done", bus.done, 1'b1);
        chk("end_busy", bus.busy, 1'b0);
        chk("end_cs", bus.CS_n, 2'b11);
        chk("end_do", bus.DO, slave_word);
        chk("end_cb", bus.cb_bit, 8'(DW));
        m_active = 1'b0;
      end else if (t >= 0) begin
        p = t / h;
        e = (p > 0) ? p - 1 : 0;
        samp = m_cpha ? e / 2 : (e + 1) / 2;
        shifts = m_cpha ? (((e + 1) / 2 > 0) ? (e + 1) / 2 - 1 : 0) : e / 2;
        if (shifts > DW - 1) shifts = DW - 1;
        exp_cs = 2'b11;
        exp_cs[m_sel] = 1'b0;
        chk("run_busy", bus.busy, 1'b1);
        chk("run_done", bus.done, 1'b0);
        chk("run_cs", bus.CS_n, exp_cs);
        chk("run_sclk", bus.SCLK, m_cpol ^ e[0]);
        chk("run_cb", bus.cb_bit, 8'(samp));
        chk("run_mosi", bus.MOSI, m_di[DW-1-shifts]);
      end
    end
  end

  // Behavioural slave: shifts slave_word out MSB first, captures MOSI.
  bit          s_active = 1'b0;
  int          s_sent = 0;
  logic [15:0] s_got = '0;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!clr) begin
      s_active = 1'b0;
      bus.MISO = 1'b0;
    end else if (bus.CS_n == 2'b11) begin
      s_active = 1'b0;
      prev_sclk = bus.SCLK;
    end else if (!s_active) begin
      s_active = 1'b1;
      s_sent = 0;
      s_got = '0;
      prev_sclk = bus.SCLK;
      if (!m_cpha) begin
        bus.MISO = slave_word[15];
        s_sent = 1;
      end
    end else if (bus.SCLK != prev_sclk) begin
      prev_sclk = bus.SCLK;
      if ((bus.SCLK != m_cpol) ^ m_cpha) begin
        s_got = {s_got[14:0], bus.MOSI};
      end else if (s_sent < 16) begin
        bus.MISO = slave_word[15-s_sent];
        s_sent++;
      end
    end
  end

  int   n_done = 0;
  int   done_t = 0;
  int   n_cs0_fall = 0;
  logic prev_cs0 = 1'b1;

  always @(negedge clk) begin
    if (clr && bus.done) begin
      n_done++;
      done_t = cyc - m_t0;
    end
    if (prev_cs0 && !bus.CS_n[0]) n_cs0_fall++;
    prev_cs0 = bus.CS_n[0];
  end

  task automatic start_xfer(input logic [15:0] di, input int d, input logic [1:0] mode,
                            input logic [1:0] sel, input bit track);
    @(negedge clk);
    bus.DI = di;
    bus.div = 8'(d);
    bus.cpol = mode[1];
    bus.cpha = mode[0];
    bus.cs_sel = sel;
    bus.st = 1'b1;
    if (track) begin
      m_t0 = cyc + 1;
      m_di = di;
      m_div = d;
      m_cpol = mode[1];
      m_cpha = mode[0];
      m_sel = sel;
      m_active = 1'b1;
    end
    @(negedge clk);
    bus.st = 1'b0;
  endtask

  task automatic wait_model(input int budget);
    for (int i = 0; i < budget && m_active; i++) @(negedge clk);
    if (m_active) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d clk, required done", budget);
      m_active = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int d0, c0;
    bus.st = 1'b0;
    bus.abort = 1'b0;
    bus.DI = '0;
    bus.div = '0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.cs_sel = '0;

    #1 clr = 1'b0;
    idle(3);
    chk("rst_sclk", bus.SCLK, 1'b0);
    chk("rst_mosi", bus.MOSI, 1'b0);
    chk("rst_cs", bus.CS_n, 2'b11);
    chk("rst_do", bus.DO, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_cb", bus.cb_bit, 8'd0);
    chk("rst_state", dbg_state, ST_IDLE);
    clr = 1'b1;
    idle(2);

    // Mode 0, div=1.
    start_xfer(16'hA5C3, 1, SPI_MODE0, 2'd0, 1'b1);
    wait_model(200);
    chk("m0_done_clk", done_t, 68);
    chk("m0_do", bus.DO, 16'h3C5A);
    chk("m0_slave_rx", s_got, 16'hA5C3);
    idle(3);

    // Mode 3, div=3: SCLK idles high.
    bus.cpol = 1'b1;
    idle(2);
    chk("m3_idle_sclk", bus.SCLK, 1'b1);
    start_xfer(16'hA5C3, 3, SPI_MODE3, 2'd0, 1'b1);
    wait_model(300);
    chk("m3_done_clk", done_t, 136);
    chk("m3_do", bus.DO, 16'h3C5A);
    chk("m3_slave_rx", s_got, 16'hA5C3);
    idle(3);

    // Second st at clk 10 of a running transfer is ignored.
    d0 = n_done;
    c0 = n_cs0_fall;
    start_xfer(16'hA5C3, 1, SPI_MODE0, 2'd0, 1'b1);
    idle(9);
    bus.DI = 16'hFFFF;
    bus.st = 1'b1;
    @(negedge clk);
    bus.st = 1'b0;
    wait_model(200);
    idle(10);
    chk("st_busy_dones", n_done - d0, 1);
    chk("st_busy_cs_windows", n_cs0_fall - c0, 1);
    chk("st_busy_slave_rx", s_got, 16'hA5C3);

    // Slave 1 then an out-of-range index.
    start_xfer(16'h1234, 0, SPI_MODE1, 2'd1, 1'b1);
    chk("sel1_cs", bus.CS_n, 2'b01);
    wait_model(100);
    chk("sel1_slave_rx", s_got, 16'h1234);
    idle(2);
    start_xfer(16'h5555, 0, SPI_MODE0, 2'd2, 1'b0);
    chk("sel2_err", bus.err, 1'b1);
    chk("sel2_busy", bus.busy, 1'b0);
    chk("sel2_cs", bus.CS_n, 2'b11);
    @(negedge clk);
    chk("sel2_err_pulse", bus.err, 1'b0);
    chk("sel2_busy_after", bus.busy, 1'b0);
    idle(2);

    // Abort raised at clk 20 of a transfer.
    d0 = n_done;
    start_xfer(16'hA5C3, 1, SPI_MODE0, 2'd0, 1'b1);
    idle(20);
    bus.abort = 1'b1;
    m_active = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_cs", bus.CS_n, 2'b11);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_sclk", bus.SCLK, 1'b0);
    chk("abort_cb", bus.cb_bit, 8'd0);
    chk("abort_done", bus.done, 1'b0);
    idle(80);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_do_kept", bus.DO, 16'h3C5A);

    // Asynchronous clr mid-XFER in mode 2, then a normal transfer.
    start_xfer(16'hA5C3, 1, SPI_MODE2, 2'd0, 1'b1);
    idle(30);
    #2 clr = 1'b0;
    m_active = 1'b0;
    #1;
    chk("clr_sclk", bus.SCLK, 1'b0);
    chk("clr_mosi", bus.MOSI, 1'b0);
    chk("clr_cs", bus.CS_n, 2'b11);
    chk("clr_do", bus.DO, 16'h0000);
    chk("clr_busy", bus.busy, 1'b0);
    chk("clr_cb", bus.cb_bit, 8'd0);
    chk("clr_state", dbg_state, ST_IDLE);
    idle(3);
    clr = 1'b1;
    idle(2);
    start_xfer(16'hC0DE, 1, SPI_MODE0, 2'd0, 1'b1);
    wait_model(200);
    chk("post_clr_done_clk", done_t, 68);
    chk("post_clr_do", bus.DO, 16'h3C5A);
    chk("post_clr_slave_rx", s_got, 16'hC0DE);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
